// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter/sequencer sharing one alu among four requesters
//
// Purpose: picks one of four requesters round-robin, latches its operands,
// runs the alu chip-select handshake, and returns result/carry/error with a
// one-hot done pulse to the granted requester.
//
// Optional feature: define ALU_ARB_TIMEOUT_EN to compile in a watchdog that
// aborts the alu wait states after TIMEOUT cycles (err=1, res=0).
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   req[3:0]              per-requester level request, held until gnt
//   req_a/req_b[63:0]     packed 16-bit operands, requester i at [16i+15:16i]
//   req_op[11:0]          packed 3-bit opcodes, requester i at [3i+2:3i]
//   gnt[3:0]              one-hot pulse: request accepted, operands latched
//   done[3:0]             one-hot pulse: res/res_cout/err valid
//   res, res_cout, err    registered result, carry and error flag
//   busy                  high whenever not idle
//   alu_a, alu_b, alu_op  operands/opcode to the shared alu
//   alu_cs                alu chip select, one cycle per operation
//   alu_out, alu_cout     alu result and carry
//   alu_rdy               alu ready: low while busy, high when idle/finished

module alu_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [11:0] req_op,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [15:0] res,
    output logic        res_cout,
    output logic        err,
    output logic        busy,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_cs,
    input  logic [15:0] alu_out,
    input  logic        alu_cout,
    input  logic        alu_rdy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam logic [2:0] OP_ILLEGAL = 3'd3;

    state_t      state;
    state_t      state_nx;

    logic [1:0]  ptr;
    logic [1:0]  win;
    logic [1:0]  owner;
    logic        any_req;

    logic [15:0] a_slice  [4];
    logic [15:0] b_slice  [4];
    logic [2:0]  op_slice [4];

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  op_code;

    logic        accept;
    logic        capture;
    logic        abort;

    // Unpack the per-requester fields once so the rest of the logic can
    // index them by the winner number.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_slice[i]  = req_a[16*i +: 16];
            b_slice[i]  = req_b[16*i +: 16];
            op_slice[i] = req_op[3*i +: 3];
        end
    end

    assign any_req = |req;

    // Round-robin pick: first requester found scanning upward from ptr,
    // wrapping modulo 4.
    always_comb begin : rr_pick
        logic [1:0] idx;
        logic       found;
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;

    // Zero during ISSUE so the first wait cycle sees 0; counts every wait
    // cycle after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        done     = 4'b0000;
        busy     = (state != IDLE);
        alu_cs   = (state == ISSUE);

        case (state)
            IDLE: begin
                if (any_req) begin
                    accept = 1'b1;
                    // Op 3 has no alu path; answering directly avoids a hang.
                    state_nx = (op_slice[win] == OP_ILLEGAL) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!alu_rdy) begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (alu_rdy) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                done     = 4'b0001 << owner;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

`ifdef ALU_ARB_TIMEOUT_EN
        // A completion in the same cycle as expiry still wins.
        if ((state == WAIT_BUSY || state == WAIT_DONE) && !capture &&
            wd_cnt == CW'(TIMEOUT - 1)) begin
            abort    = 1'b1;
            state_nx = RESP;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= 4'b0000;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            op_a     <= 16'h0000;
            op_b     <= 16'h0000;
            op_code  <= 3'd0;
            res      <= 16'h0000;
            res_cout <= 1'b0;
            err      <= 1'b0;
        end else begin
            gnt <= 4'b0000;
            if (accept) begin
                gnt     <= 4'b0001 << win;
                owner   <= win;
                ptr     <= win + 2'd1;
                op_a    <= a_slice[win];
                op_b    <= b_slice[win];
                op_code <= op_slice[win];
                if (op_slice[win] == OP_ILLEGAL) begin
                    res      <= 16'h0000;
                    res_cout <= 1'b0;
                    err      <= 1'b1;
                end
            end
            if (capture) begin
                res      <= alu_out;
                res_cout <= alu_cout;
                err      <= 1'b0;
            end
            if (abort) begin
                res      <= 16'h0000;
                res_cout <= 1'b0;
                err      <= 1'b1;
            end
        end
    end

    // Operand registers only change on accept, so the alu inputs are stable
    // from ISSUE through WAIT_DONE.
    assign alu_a  = op_a;
    assign alu_b  = op_b;
    assign alu_op = op_code;

endmodule
